// File: rtl/game_result_detector.sv
// Tic-tac-toe result detector: captures each accepted move, evaluates the board one
// cycle later, and reports the winner, draw or conflict with a single score pulse per win.
module game_result_detector (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] board,
    input  logic        move_valid,
    input  logic        new_game,
    output logic        incrementX,
    output logic        incrementO,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [7:0]  win_line,
    output logic        conflict,
    output logic [3:0]  move_count
);

    typedef enum logic [1:0] {PLAYING, EVAL, REPORT, OVER} state_t;

    state_t      state, state_next;
    logic [17:0] captured, captured_next;
    logic        inc_x_next, inc_o_next, game_over_next, conflict_next;
    logic [1:0]  winner_next;
    logic [7:0]  win_line_next;
    logic [3:0]  move_count_next;
    logic [7:0]  x_lines, o_lines;
    logic        board_full;

    // Bit order matches win_line: rows, then columns, then the two diagonals.
    function automatic logic [7:0] lines_of(input logic [17:0] b, input logic [1:0] player);
        logic [8:0] m;
        for (int i = 0; i < 9; i++) m[i] = (b[2*i +: 2] == player);
        return {m[2] & m[4] & m[6], m[0] & m[4] & m[8],
                m[2] & m[5] & m[8], m[1] & m[4] & m[7], m[0] & m[3] & m[6],
                m[6] & m[7] & m[8], m[3] & m[4] & m[5], m[0] & m[1] & m[2]};
    endfunction

    function automatic logic is_full(input logic [17:0] b);
        logic f;
        f = 1'b1;
        for (int i = 0; i < 9; i++) f = f & (b[2*i] ^ b[2*i+1]);
        return f;
    endfunction

    // Only the captured board is evaluated, so the live input may change freely.
    assign x_lines    = lines_of(captured, 2'b01);
    assign o_lines    = lines_of(captured, 2'b10);
    assign board_full = is_full(captured);

    always_comb begin
        // NOTE: every next value defaults to hold/idle first so no latch can be inferred.
        state_next      = state;
        captured_next   = captured;
        inc_x_next      = 1'b0;
        inc_o_next      = 1'b0;
        game_over_next  = game_over;
        winner_next     = winner;
        win_line_next   = win_line;
        conflict_next   = conflict;
        move_count_next = move_count;

        case (state)
            PLAYING: if (move_valid) begin
                captured_next = board;
                if (move_count != 4'd9) move_count_next = move_count + 4'd1;
                state_next = EVAL;
            end
            EVAL: begin
                if (|x_lines && |o_lines) begin
                    conflict_next  = 1'b1;
                    winner_next    = 2'b00;
                    game_over_next = 1'b1;
                    state_next     = OVER;
                end else if (|x_lines) begin
                    winner_next   = 2'b01;
                    win_line_next = x_lines;
                    inc_x_next    = 1'b1;
                    state_next    = REPORT;
                end else if (|o_lines) begin
                    winner_next   = 2'b10;
                    win_line_next = o_lines;
                    inc_o_next    = 1'b1;
                    state_next    = REPORT;
                end else if (board_full) begin
                    winner_next    = 2'b11;
                    game_over_next = 1'b1;
                    state_next     = OVER;
                end else begin
                    state_next = PLAYING;
                end
            end
            REPORT: begin
                game_over_next = 1'b1;
                state_next     = OVER;
            end
            default: ;
        endcase

        // A new game overrides everything, including a move strobed in the same cycle.
        if (new_game) begin
            state_next      = PLAYING;
            captured_next   = '0;
            inc_x_next      = 1'b0;
            inc_o_next      = 1'b0;
            game_over_next  = 1'b0;
            winner_next     = 2'b00;
            win_line_next   = '0;
            conflict_next   = 1'b0;
            move_count_next = '0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PLAYING;
            captured   <= '0;
            incrementX <= 1'b0;
            incrementO <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            win_line   <= '0;
            conflict   <= 1'b0;
            move_count <= '0;
        end else begin
            state      <= state_next;
            captured   <= captured_next;
            incrementX <= inc_x_next;
            incrementO <= inc_o_next;
            game_over  <= game_over_next;
            winner     <= winner_next;
            win_line   <= win_line_next;
            conflict   <= conflict_next;
            move_count <= move_count_next;
        end
    end

endmodule

// File: tb/tb_game_result_detector.sv
// Directed bench for game_result_detector: wins, draw, conflict, reset and new_game cases
// with hand-computed expectations checked by immediate assertions.
module tb_game_result_detector;

    logic        clk = 1'b0;
    logic        reset, move_valid, new_game;
    logic [17:0] board;
    logic        incrementX, incrementO, game_over, conflict;
    logic [1:0]  winner;
    logic [7:0]  win_line;
    logic [3:0]  move_count;

    int checks = 0;
    int errors = 0;
    int px = 0, po = 0, both = 0;
    int px0, po0;

    game_result_detector dut (
        .clk(clk), .reset(reset), .board(board), .move_valid(move_valid),
        .new_game(new_game), .incrementX(incrementX), .incrementO(incrementO),
        .game_over(game_over), .winner(winner), .win_line(win_line),
        .conflict(conflict), .move_count(move_count)
    );

    always #5 clk = ~clk;

    // Pulse tally sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (incrementX === 1'b1) px++;
        if (incrementO === 1'b1) po++;
        if (incrementX === 1'b1 && incrementO === 1'b1) both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [8:0] xm, input logic [8:0] om);
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++)
            b[2*i +: 2] = xm[i] ? 2'b01 : (om[i] ? 2'b10 : 2'b00);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input logic [17:0] b);
        board = b;
        move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
    endtask

    task automatic play(input logic [17:0] b);
        move(b);
        tick();
    endtask

    task automatic start_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    logic [8:0] dx [9] = '{9'h001, 9'h001, 9'h005, 9'h005, 9'h00D, 9'h00D, 9'h08D, 9'h08D, 9'h18D};
    logic [8:0] dox[9] = '{9'h000, 9'h002, 9'h002, 9'h012, 9'h012, 9'h032, 9'h032, 9'h072, 9'h072};

    initial begin
        reset = 1'b0; move_valid = 1'b0; new_game = 1'b0; board = '0;
        #12;
        check("rst_incx", incrementX, 0);
        check("rst_over", game_over, 0);
        check("rst_winner", winner, 0);
        check("rst_count", move_count, 0);
        @(posedge clk); #1 reset = 1'b1;

        // X wins row 0 on the fifth move.
        px0 = px; po0 = po;
        play(mk(9'h001, 9'h000));
        play(mk(9'h001, 9'h008));
        play(mk(9'h003, 9'h008));
        play(mk(9'h003, 9'h018));
        check("x_mid_winner", winner, 0);
        check("x_mid_count", move_count, 4);
        move(mk(9'h007, 9'h018));
        check("x_count", move_count, 5);
        tick();
        check("x_pulse", incrementX, 1);
        check("x_no_o", incrementO, 0);
        check("x_winner", winner, 2'b01);
        check("x_line", win_line, 8'h01);
        tick();
        check("x_pulse_end", incrementX, 0);
        check("x_over", game_over, 1);
        tick(); tick();
        check("x_pulses", px - px0, 1);
        check("x_opulses", po - po0, 0);

        // Full board without a line is a draw.
        start_game();
        px0 = px; po0 = po;
        for (int i = 0; i < 8; i++) play(mk(dx[i], dox[i]));
        check("d_mid_winner", winner, 0);
        move(mk(dx[8], dox[8]));
        tick();
        check("d_winner", winner, 2'b11);
        check("d_over", game_over, 1);
        check("d_count", move_count, 9);
        move(mk(9'h1FF, 9'h000));
        tick();
        check("d_count_hold", move_count, 9);
        check("d_pulses", (px - px0) + (po - po0), 0);

        // O wins row 1; a later move must not disturb the result.
        start_game();
        check("ng_winner", winner, 0);
        check("ng_count", move_count, 0);
        px0 = px; po0 = po;
        play(mk(9'h001, 9'h000));
        play(mk(9'h001, 9'h008));
        play(mk(9'h003, 9'h008));
        play(mk(9'h003, 9'h018));
        play(mk(9'h103, 9'h018));
        move(mk(9'h103, 9'h038));
        tick();
        check("o_pulse", incrementO, 1);
        check("o_winner", winner, 2'b10);
        check("o_line", win_line, 8'h02);
        tick();
        check("o_over", game_over, 1);
        move(mk(9'h107, 9'h038));
        tick(); tick();
        check("o_hold_winner", winner, 2'b10);
        check("o_hold_line", win_line, 8'h02);
        check("o_hold_count", move_count, 6);
        check("o_xpulses", px - px0, 0);
        check("o_opulses", po - po0, 1);
        start_game();
        check("o_clr_winner", winner, 0);
        check("o_clr_line", win_line, 0);
        check("o_clr_over", game_over, 0);
        check("o_clr_conflict", conflict, 0);
        check("o_clr_count", move_count, 0);
        move(mk(9'h001, 9'h000));
        check("o_clr_playing", move_count, 1);
        tick();

        // X holds row 0 and the main diagonal at once.
        start_game();
        px0 = px;
        move(mk(9'h117, 9'h068));
        tick();
        check("dbl_line", win_line, 8'h41);
        check("dbl_winner", winner, 2'b01);
        tick(); tick();
        check("dbl_pulses", px - px0, 1);

        // Both players hold a line.
        start_game();
        px0 = px; po0 = po;
        move(mk(9'h007, 9'h038));
        tick();
        check("cf_conflict", conflict, 1);
        check("cf_winner", winner, 0);
        check("cf_over", game_over, 1);
        tick();
        check("cf_pulses", (px - px0) + (po - po0), 0);

        // Reset while the winning board is being evaluated.
        start_game();
        px0 = px;
        move(mk(9'h007, 9'h000));
        reset = 1'b0;
        #1;
        check("rs_count", move_count, 0);
        check("rs_incx", incrementX, 0);
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        check("rs_pulses", px - px0, 0);
        check("rs_winner", winner, 0);

        // new_game beats a simultaneous winning move.
        px0 = px;
        board = mk(9'h007, 9'h000);
        move_valid = 1'b1;
        new_game = 1'b1;
        tick();
        move_valid = 1'b0;
        new_game = 1'b0;
        tick(); tick();
        check("sim_count", move_count, 0);
        check("sim_winner", winner, 0);
        check("sim_pulses", px - px0, 0);

        check("never_both", both, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
